sprite_mover: RTL and testbench
===============================

// Module: sprite_mover
// PURPOSE
// - Square sprite on the OLED frame (default 96x64, RGB565), steered by the five buttons, drawn against the
//   display driver's pixel_index stream. Runs on the 100 MHz clk.
// - Generalises the single-speed button mover: parametrised screen/sprite size, home point, four directions
//   (down included), two selectable step rates, explicit FSM, one-cycle registered pixel output.
// PARAMETERS
// - SCREEN_W     96           frame width, pixels
// - SCREEN_H     64           frame height, pixels
// - SPRITE_SZ    5            sprite edge length, pixels (1..min(SCREEN_W,SCREEN_H))
// - HOME_X       46           top-left x after centring
// - HOME_Y       59           top-left y after centring (must satisfy HOME_Y <= SCREEN_H-SPRITE_SZ)
// - CLK_HZ       100_000_000  clk frequency
// - SLOW_HZ      15           step rate when mode=1
// - FAST_HZ      45           step rate when mode=0
// - IDX_W        13           pixel_index width (>= clog2(SCREEN_W*SCREEN_H))
// PORTS
// - clk          in   1      system clock
// - reset        in   1      asynchronous, active-high reset
// - enable       in   1      block selected; while 0, buttons are ignored (motion continues, drawing continues)
// - mode         in   1      0 = FAST_HZ steps, 1 = SLOW_HZ steps
// - btnC/U/D/L/R in   1 each debounced levels, synchronous to clk
// - pixel_index  in   IDX_W  raster index from the OLED driver, row-major
// - pixel_data   out  16     RGB565 colour for pixel_index
// - moving       out  1      high in any MOVE_* state
// - pos_x        out  8      current sprite top-left x
// - pos_y        out  8      current sprite top-left y
// BEHAVIOUR
// - Reset (async): state=IDLE, pos=(HOME_X,HOME_Y), pixel_data=0, moving=0, tick counter=0.
// - FSM: IDLE, ARMED, MOVE_U, MOVE_D, MOVE_L, MOVE_R.
//   IDLE  -> ARMED on btnC&enable (pos <= HOME). Sprite drawn blue (16'h001F); direction buttons ignored.
//   ARMED -> MOVE_x on button x & enable, only if not already at that edge; priority U>D>L>R.
//   MOVE_x-> MOVE_y on button y & enable (y != x, not at that edge); same priority; allowed mid-move.
//   MOVE_x-> ARMED when a step lands on the edge in direction x (x=0, y=0, x=SCREEN_W-SPRITE_SZ or
//             y=SCREEN_H-SPRITE_SZ); sprite never leaves the frame, no wrap-around.
//   btnC while moving: ignored. btnC in ARMED: re-centre to HOME, stay ARMED.
//   ARMED/MOVE_*: sprite drawn white (16'hFFFF).
// - Step tick: counter period P = CLK_HZ/rate - 1, one-cycle pulse at terminal count; pos updates by exactly
//   1 pixel on the tick edge. mode change or any FSM transition clears the counter (first step a full period later).
// - Tick and direction change on the same cycle: step applies in the new direction.
// - Render: x = pixel_index % SCREEN_W, y = pixel_index / SCREEN_W; inside iff pos_x<=x<pos_x+SPRITE_SZ and
//   pos_y<=y<pos_y+SPRITE_SZ; outside -> 16'h0000. Latency exactly 1 clk from pixel_index to pixel_data.
//   pixel_index >= SCREEN_W*SCREEN_H -> 16'h0000.
// - Comparisons in 9-bit unsigned to avoid overflow of pos+SPRITE_SZ.
// STRUCTURE
// - Package oled_pkg: RGB565 constants (BLACK, WHITE, BLUE, RED, GREEN), state enum / localparams, screen defaults.
// - Sub-module rate_ticker (params CLK_HZ, RATE_HZ; ports clk, reset, clear, tick): instantiated twice (slow/fast),
//   mode-muxed output.
// - FSM + position regs + render comparator in this file.
// TESTING (bench overrides CLK_HZ=90, FAST_HZ=45, SLOW_HZ=15 -> tick every 2 / 6 clks)
// - Reset mid-move at pos (50,59) -> next cycle pos=(46,59), IDLE, pixel_data=0, moving=0.
// - btnC 1 clk from IDLE -> ARMED, pos=(46,59); pixel_index=59*96+46 -> 16'hFFFF one clk later; index 58*96+46 -> 0.
// - ARMED, btnR pulse, mode=0 -> pos_x increments every 2 clks, 46..91, then ARMED, moving=0, pos_x holds 91.
// - MOVE_U, mode=1 -> steps every 6 clks; btnL+btnD same cycle -> MOVE_D (priority), at y=59 returns ARMED.
// - btnC while MOVE_L -> ignored, pos continues; enable=0 with btnU -> no state change.
// - Sprite at (0,0), btnU/btnL -> stays ARMED; pixel_index=6143 -> 0; pixel_index=6144 -> 0.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared OLED definitions: RGB565 colours, default frame size and the
// sprite mover's state encoding.
package oled_pkg;

  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] BLUE  = 16'h001F;
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] GREEN = 16'h07E0;

  localparam int SCREEN_W_DEF = 96;
  localparam int SCREEN_H_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    MOVE_U,
    MOVE_D,
    MOVE_L,
    MOVE_R
  } moverState;

endpackage

// File: rtl/rate_ticker.sv
// Free-running divider producing a one-cycle pulse every CLK_HZ/RATE_HZ clocks.
// The pulse is decoded from the count, so a clear on the pulse cycle still
// lets that pulse be used; the next one then comes a full period later.
module rate_ticker #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int RATE_HZ = 45
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int PERIOD = CLK_HZ / RATE_HZ;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  assign tick = (count == TERMINAL);

  // Count up to the terminal value, restart on wrap or on clear.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    if (reset)                count <= '0;
    else if (clear || tick)   count <= '0;
    else                      count <= count + 1'b1;
  end

endmodule

// File: rtl/sprite_mover.sv
// Button-steered square sprite drawn over the OLED raster. Four-direction
// motion at one of two step rates; the sprite stops on whichever edge it
// runs into and never wraps.
module sprite_mover
  import oled_pkg::*;
#(
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int SPRITE_SZ = 5,
  parameter int HOME_X    = 46,
  parameter int HOME_Y    = 59,
  parameter int CLK_HZ    = 100_000_000,
  parameter int SLOW_HZ   = 15,
  parameter int FAST_HZ   = 45,
  parameter int IDX_W     = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             btnC,
  input  logic             btnU,
  input  logic             btnD,
  input  logic             btnL,
  input  logic             btnR,
  input  logic [IDX_W-1:0] pixel_index,
  output logic [15:0]      pixel_data,
  output logic             moving,
  output logic [7:0]       pos_x,
  output logic [7:0]       pos_y
);

  // Edge limits and home point, in the 9-bit domain used for all compares so
  // pos + SPRITE_SZ cannot overflow.
  localparam logic [8:0] MAX_X  = 9'(SCREEN_W - SPRITE_SZ);
  localparam logic [8:0] MAX_Y  = 9'(SCREEN_H - SPRITE_SZ);
  localparam logic [8:0] SIZE9  = 9'(SPRITE_SZ);
  localparam logic [7:0] HOME_X8 = 8'(HOME_X);
  localparam logic [7:0] HOME_Y8 = 8'(HOME_Y);
  localparam logic [IDX_W-1:0] FRAME_PIX = IDX_W'(SCREEN_W * SCREEN_H);
  localparam logic [IDX_W-1:0] ROW_LEN   = IDX_W'(SCREEN_W);

  moverState  state, stateNext, dirNext;
  logic [7:0] xNext, yNext;
  logic [8:0] posX9, posY9;
  logic       canU, canD, canL, canR;
  logic       modeQ, modeChanged;
  logic       slowTick, fastTick, stepTick, tickClear;

  assign posX9 = {1'b0, pos_x};
  assign posY9 = {1'b0, pos_y};

  // A direction is eligible only when requested and the sprite is not already
  // against that edge.
  assign canU = enable & btnU & (posY9 != 9'd0);
  assign canD = enable & btnD & (posY9 != MAX_Y);
  assign canL = enable & btnL & (posX9 != 9'd0);
  assign canR = enable & btnR & (posX9 != MAX_X);

  assign moving = (state == MOVE_U) || (state == MOVE_D) ||
                  (state == MOVE_L) || (state == MOVE_R);

  // A mode switch restarts the period and suppresses a coincident pulse.
  assign modeChanged = (mode != modeQ);
  assign stepTick    = (mode ? slowTick : fastTick) & ~modeChanged;
  assign tickClear   = (stateNext != state) || modeChanged;

  rate_ticker #(.CLK_HZ(CLK_HZ), .RATE_HZ(SLOW_HZ)) slowTicker (
    .clk   (clk),
    .reset (reset),
    .clear (tickClear),
    .tick  (slowTick)
  );

  rate_ticker #(.CLK_HZ(CLK_HZ), .RATE_HZ(FAST_HZ)) fastTicker (
    .clk   (clk),
    .reset (reset),
    .clear (tickClear),
    .tick  (fastTick)
  );

  // Next state and next position; a step always uses the direction chosen
  // this cycle, so a turn on a tick edge moves the new way.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    stateNext = state;
    dirNext   = state;
    xNext     = pos_x;
    yNext     = pos_y;
    case (state)
      IDLE: begin
        if (enable && btnC) begin
          stateNext = ARMED;
          xNext     = HOME_X8;
          yNext     = HOME_Y8;
        end
      end
      ARMED: begin
        if (enable && btnC) begin
          xNext = HOME_X8;
          yNext = HOME_Y8;
        end
        else if (canU) stateNext = MOVE_U;
        else if (canD) stateNext = MOVE_D;
        else if (canL) stateNext = MOVE_L;
        else if (canR) stateNext = MOVE_R;
      end
      MOVE_U, MOVE_D, MOVE_L, MOVE_R: begin
        if      (canU && state != MOVE_U) dirNext = MOVE_U;
        else if (canD && state != MOVE_D) dirNext = MOVE_D;
        else if (canL && state != MOVE_L) dirNext = MOVE_L;
        else if (canR && state != MOVE_R) dirNext = MOVE_R;
        stateNext = dirNext;
        if (stepTick) begin
          case (dirNext)
            MOVE_U: begin
              yNext = pos_y - 8'd1;
              if (posY9 == 9'd1) stateNext = ARMED;
            end
            MOVE_D: begin
              yNext = pos_y + 8'd1;
              if (posY9 + 9'd1 == MAX_Y) stateNext = ARMED;
            end
            MOVE_L: begin
              xNext = pos_x - 8'd1;
              if (posX9 == 9'd1) stateNext = ARMED;
            end
            default: begin
              xNext = pos_x + 8'd1;
              if (posX9 + 9'd1 == MAX_X) stateNext = ARMED;
            end
          endcase
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, position and last-seen mode registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pos_x <= HOME_X8;
      pos_y <= HOME_Y8;
      modeQ <= 1'b0;
    end
    else begin
      state <= stateNext;
      pos_x <= xNext;
      pos_y <= yNext;
      modeQ <= mode;
    end
  end

  // Raster coordinate of the incoming index, reduced to the 9-bit domain.
  logic [8:0] pixX9, pixY9;
  logic       inFrame, inSprite;

  assign pixX9    = 9'(pixel_index % ROW_LEN);
  assign pixY9    = 9'(pixel_index / ROW_LEN);
  assign inFrame  = (pixel_index < FRAME_PIX);
  assign inSprite = (pixX9 >= posX9) && (pixX9 < posX9 + SIZE9) &&
                    (pixY9 >= posY9) && (pixY9 < posY9 + SIZE9);

  // One-cycle registered colour lookup: blue while idle, white otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    pixel_data <= BLACK;
    else if (inFrame && inSprite) pixel_data <= (state == IDLE) ? BLUE : WHITE;
    else                          pixel_data <= BLACK;
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: directed scenarios plus a random phase, all checked
// cycle by cycle against a coordinate/velocity reference model.
module tb_sprite_mover;

  logic        clk = 1'b0;
  logic        reset, enable, mode;
  logic        btnC, btnU, btnD, btnL, btnR;
  logic [12:0] pixel_index;
  logic [15:0] pixel_data;
  logic        moving;
  logic [7:0]  pos_x, pos_y;

  int nTests = 0;
  int nFail  = 0;

  sprite_mover #(.CLK_HZ(90), .SLOW_HZ(15), .FAST_HZ(45)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .btnC        (btnC),
    .btnU        (btnU),
    .btnD        (btnD),
    .btnL        (btnL),
    .btnR        (btnR),
    .pixel_index (pixel_index),
    .pixel_data  (pixel_data),
    .moving      (moving),
    .pos_x       (pos_x),
    .pos_y       (pos_y)
  );

  always #5 clk = ~clk;

  // Reference model: kind 0 idle, 1 armed, 2 moving with velocity (mDx,mDy);
  // mAge = clocks since the step timer last restarted.
  int          mKind, mX, mY, mDx, mDy, mAge;
  bit          mModePrev;
  logic [15:0] mPix;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    mKind = 0; mX = 46; mY = 59; mDx = 0; mDy = 0; mAge = 0;
    mModePrev = 1'b0; mPix = 16'h0000;
  endfunction

  function automatic logic [15:0] refPixel(int idx);
    int px = idx % 96;
    int py = idx / 96;
    if (idx >= 96 * 64) return 16'h0000;
    if (px >= mX && px < mX + 5 && py >= mY && py < mY + 5)
      return (mKind == 0) ? 16'h001F : 16'hFFFF;
    return 16'h0000;
  endfunction

  // First eligible requested direction in U>D>L>R order, skipping the current one.
  function automatic bit chooseDir(int curDx, int curDy, output int ndx, output int ndy);
    int cx[4] = '{0, 0, -1, 1};
    int cy[4] = '{-1, 1, 0, 0};
    bit req[4];
    bit ok[4];
    req = '{btnU, btnD, btnL, btnR};
    ok  = '{mY > 0, mY < 59, mX > 0, mX < 91};
    ndx = 0; ndy = 0;
    if (!enable) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (req[i] && ok[i] && !(cx[i] == curDx && cy[i] == curDy)) begin
        ndx = cx[i]; ndy = cy[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void modelStep();
    int  period  = mode ? 6 : 2;
    bit  modeChg = (mode != mModePrev);
    bit  stepNow = !modeChg && (mAge % period == period - 1);
    bit  changed = 1'b0;
    int  ndx, ndy;
    mPix = refPixel(int'(pixel_index));
    if (mKind == 0) begin
      if (enable && btnC) begin mKind = 1; mX = 46; mY = 59; changed = 1'b1; end
    end
    else if (mKind == 1) begin
      if (enable && btnC) begin mX = 46; mY = 59; end
      else if (chooseDir(99, 99, ndx, ndy)) begin
        mKind = 2; mDx = ndx; mDy = ndy; changed = 1'b1;
      end
    end
    else begin
      if (chooseDir(mDx, mDy, ndx, ndy)) begin mDx = ndx; mDy = ndy; changed = 1'b1; end
      if (stepNow) begin
        mX += mDx; mY += mDy;
        if ((mDx < 0 && mX == 0) || (mDx > 0 && mX == 91) ||
            (mDy < 0 && mY == 0) || (mDy > 0 && mY == 59)) begin
          mKind = 1; changed = 1'b1;
        end
      end
    end
    mAge = (changed || modeChg) ? 0 : mAge + 1;
    mModePrev = mode;
  endfunction

  task automatic step();
    modelStep();
    @(posedge clk);
    #1;
    check("pos_x", 32'(pos_x), 32'(mX));
    check("pos_y", 32'(pos_y), 32'(mY));
    check("moving", 32'(moving), 32'(mKind == 2));
    check("pixel", 32'(pixel_data), 32'(mPix));
  endtask

  task automatic runUntilStopped(input int bound);
    int n = 0;
    while (moving && n < bound) begin step(); n++; end
    check("stop_within_bound", 32'(moving), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b1; mode = 1'b0;
    btnC = 0; btnU = 0; btnD = 0; btnL = 0; btnR = 0;
    pixel_index = '0;
    modelReset();
    #10;
    check("rst_pos_x", 32'(pos_x), 32'd46);
    check("rst_pos_y", 32'(pos_y), 32'd59);
    check("rst_moving", 32'(moving), 32'd0);
    check("rst_pixel", 32'(pixel_data), 32'h0);
    reset = 1'b0;

    // Idle sprite is blue at home.
    pixel_index = 13'(59 * 96 + 46);
    step();
    check("idle_blue", 32'(pixel_data), 32'h001F);

    // Arm, then render white at home, black one row above.
    btnC = 1; step(); btnC = 0;
    check("arm_pos_x", 32'(pos_x), 32'd46);
    check("arm_moving", 32'(moving), 32'd0);
    step();
    check("armed_white", 32'(pixel_data), 32'hFFFF);
    pixel_index = 13'(58 * 96 + 46);
    step();
    check("row_above_black", 32'(pixel_data), 32'h0);

    // Fast right run to the right edge: 45 steps, 2 clocks each.
    mode = 0; btnR = 1; step(); btnR = 0;
    check("r_moving", 32'(moving), 32'd1);
    n = 0;
    while (moving && n < 200) begin step(); n++; end
    check("r_run_cycles", 32'(n), 32'd90);
    check("r_edge_x", 32'(pos_x), 32'd91);
    step(); step();
    check("r_hold_x", 32'(pos_x), 32'd91);
    check("r_armed", 32'(moving), 32'd0);

    // Slow up, then L+D together: down wins and returns to bottom edge.
    mode = 1; btnU = 1; step(); btnU = 0;
    repeat (13) step();
    check("u_slow_y", 32'(pos_y), 32'd57);
    btnL = 1; btnD = 1; step(); btnL = 0; btnD = 0;
    check("ld_prio_x", 32'(pos_x), 32'd91);
    check("ld_moving", 32'(moving), 32'd1);
    runUntilStopped(100);
    check("d_edge_y", 32'(pos_y), 32'd59);

    // btnC ignored mid-move; disabled buttons ignored.
    mode = 0; btnL = 1; step(); btnL = 0;
    repeat (4) step();
    btnC = 1; step(); btnC = 0;
    check("btnc_ignored_mv", 32'(moving), 32'd1);
    check("btnc_ignored_x", 32'(pos_x), 32'd89);
    enable = 0; btnU = 1;
    repeat (3) step();
    check("dis_moving", 32'(moving), 32'd1);
    check("dis_y", 32'(pos_y), 32'd59);
    check("dis_x", 32'(pos_x), 32'd87);
    enable = 1; btnU = 0;
    runUntilStopped(200);
    check("l_edge_x", 32'(pos_x), 32'd0);

    // Corner (0,0): up/left requests refused; frame boundary indices black.
    btnU = 1; step(); btnU = 0;
    runUntilStopped(200);
    check("u_edge_y", 32'(pos_y), 32'd0);
    btnU = 1; btnL = 1;
    repeat (3) step();
    btnU = 0; btnL = 0;
    check("corner_armed", 32'(moving), 32'd0);
    pixel_index = 13'd6143; step();
    check("idx_6143", 32'(pixel_data), 32'h0);
    pixel_index = 13'd6144; step();
    check("idx_6144", 32'(pixel_data), 32'h0);
    pixel_index = 13'd0; step();
    check("idx_0_white", 32'(pixel_data), 32'hFFFF);
    pixel_index = 13'd8191; step();
    check("idx_8191", 32'(pixel_data), 32'h0);

    // Re-centre, move to x=50, async reset mid-move.
    btnC = 1; step(); btnC = 0;
    check("recentre_x", 32'(pos_x), 32'd46);
    btnR = 1; step(); btnR = 0;
    n = 0;
    while (pos_x != 8'd50 && n < 20) begin step(); n++; end
    check("reach_50", 32'(pos_x), 32'd50);
    #2 reset = 1'b1;
    #1;
    check("midrst_x", 32'(pos_x), 32'd46);
    check("midrst_y", 32'(pos_y), 32'd59);
    check("midrst_moving", 32'(moving), 32'd0);
    check("midrst_pixel", 32'(pixel_data), 32'h0);
    #2 reset = 1'b0;
    modelReset();
    pixel_index = 13'(59 * 96 + 46);
    step();
    check("midrst_idle_blue", 32'(pixel_data), 32'h001F);

    // Random phase against the model.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      btnC = ($urandom_range(0, 39) == 0);
      btnU = ($urandom_range(0, 14) == 0);
      btnD = ($urandom_range(0, 14) == 0);
      btnL = ($urandom_range(0, 14) == 0);
      btnR = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 1) == 0) pixel_index = 13'($urandom_range(0, 8191));
      else pixel_index = 13'(mY * 96 + mX + int'($urandom_range(0, 480)));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
